cmp_event_qualifier: RTL and testbench
======================================

// Module: cmp_event_qualifier
// PURPOSE
//  Downstream stage of the 4-bit magnitude comparator. Consumes its 6-bit relation flag
//  vector and selects one relation. Asserts a debounced trigger once that relation holds
//  for PERSIST consecutive valid samples, and releases it after PERSIST consecutive false
//  samples (symmetric hysteresis). Counts qualified trigger events for software readout.
// PARAMETERS
//  PERSIST  3  consecutive valid samples needed to enter or leave ON; legal range 1..15
//  CNT_W    8  width of the saturating event counter
// PORTS
//  clk         in   1      single clock; all state updates on its rising edge
//  rst         in   1      synchronous, active-high reset
//  flags       in   6      comparator flags: [5]eq [4]ne [3]gt [2]lt [1]ge [0]le
//  flags_vld   in   1      flags hold a new sample this cycle
//  sel         in   3      relation index 0..5 (indexes flags[sel]); 6 and 7 are illegal
//  clr_cnt     in   1      clear event_cnt
//  trig        out  1      qualified trigger level (registered)
//  trig_pulse  out  1      one-cycle pulse on the cycle trig first reads high
//  event_cnt   out  CNT_W  number of trig rising edges; saturates at all-ones
//  sel_err     out  1      registered; high while sel is 6 or 7
// BEHAVIOUR
//  - Reset: state=IDLE, run counter=0. trig, trig_pulse, event_cnt and sel_err are all 0.
//    Reset is honoured in any state and overrides every other input.
//  - cond = (sel<6) ? flags[sel] : 0. Only cycles with flags_vld=1 are samples.
//    A cycle with flags_vld=0 holds all state and the run counter. It does not break a run.
//  - FSM states: IDLE, PEND_ON, ON, PEND_OFF. Run counter rc spans 0..PERSIST-1.
//    IDLE:     sample cond=1 -> PEND_ON with rc=1; if PERSIST==1 -> ON directly.
//    PEND_ON:  cond=1 -> rc++; the PERSIST-th consecutive 1 -> ON, rc=0.
//              cond=0 -> IDLE, rc=0.
//    ON:       cond=0 -> PEND_OFF with rc=1; if PERSIST==1 -> IDLE directly.
//    PEND_OFF: cond=0 -> rc++; the PERSIST-th consecutive 0 -> IDLE, rc=0.
//              cond=1 -> ON, rc=0.
//  - trig = (state==ON || state==PEND_OFF).
//    Latency: with PERSIST=3 and true samples in cycles 0,1,2, trig reads high from cycle 3.
//  - trig_pulse is high exactly in the first cycle trig reads 1. In that same edge,
//    event_cnt increments unless it is already all-ones.
//  - clr_cnt: event_cnt<=0 and has priority over a coincident increment.
//    The event in that cycle is lost.
//  - A sel change (sel != previous-cycle sel) in any state forces IDLE, rc=0, and trig=0
//    next cycle. It produces no trig_pulse. Qualification restarts under the new sel.
//  - Illegal sel: cond is forced to 0, so the FSM drains to IDLE. sel_err=1 one cycle
//    after sel becomes illegal.
//  - No combinational path from any input to any output.
// STRUCTURE
//  - Package cmp_pkg holds:
//    - localparams FLG_EQ=5, FLG_NE=4, FLG_GT=3, FLG_LT=2, FLG_GE=1, FLG_LE=0;
//    - the SEL_* encodings 0..5 (SEL_* = FLG_* index);
//    - enum qual_state_t {IDLE, PEND_ON, ON, PEND_OFF}, 2 bits.
//  - Sub-module cmp_persist_ctr owns the run counter:
//    - inputs inc, clr, parameter PERSIST;
//    - output done, asserted when the incoming sample is the PERSIST-th.
//  - Top level holds the FSM, the sel register, the event counter and output registers.
// TESTING
//  - Reset: drive rst=1 for 2 cycles with random inputs -> all outputs 0 and state IDLE.
//    Repeat the check with reset asserted while in ON.
//  - Qualify: PERSIST=3, sel=3 (gt), flags_vld=1; flags=6'b011010 for 3 cycles
//    (A=14,B=13) -> trig=1 and trig_pulse=1 on cycle 3 only; event_cnt=1.
//  - Gaps and glitch: the same run with flags_vld=0 between samples -> same result,
//    delayed by the gap count. A run of 2 true samples, 1 false, 3 true ->
//    a single trigger after the final 3.
//  - Hysteresis: in ON, 2 false samples then 1 true -> trig stays 1.
//    3 false samples -> trig=0 next cycle; event_cnt is unchanged.
//  - Saturation and clear: CNT_W=2, 4 qualified events -> event_cnt=3.
//    clr_cnt coincident with the 5th trig rise -> event_cnt=0.
//  - sel handling: sel switched 3->5 while ON -> trig=0 next cycle, no pulse.
//    sel=6 -> sel_err=1 and trig never asserts. PERSIST=1 -> trig follows cond with 1 cycle latency.

Source files
------------

// File: rtl/cmp_pkg.sv
// ---------------------------------------------------------------------------
// cmp_pkg
//   Shared definitions for the comparator event-qualifier slice.
//   - FLG_* : bit positions of the 6-bit comparator relation flag vector.
//   - SEL_* : relation-select encodings; each equals the flag bit it picks.
//   - qual_state_t : debounce FSM state encoding.
//   - RC_W  : run-counter width, wide enough for PERSIST-1 up to 14.
//   - select_flag() : picks flags[sel], yielding 0 for the illegal sel 6/7.
// ---------------------------------------------------------------------------
package cmp_pkg;

    localparam int FLG_EQ = 5;
    localparam int FLG_NE = 4;
    localparam int FLG_GT = 3;
    localparam int FLG_LT = 2;
    localparam int FLG_GE = 1;
    localparam int FLG_LE = 0;

    localparam logic [2:0] SEL_EQ = 3'(FLG_EQ);
    localparam logic [2:0] SEL_NE = 3'(FLG_NE);
    localparam logic [2:0] SEL_GT = 3'(FLG_GT);
    localparam logic [2:0] SEL_LT = 3'(FLG_LT);
    localparam logic [2:0] SEL_GE = 3'(FLG_GE);
    localparam logic [2:0] SEL_LE = 3'(FLG_LE);

    // Run counter holds 0..PERSIST-1 with PERSIST at most 15.
    localparam int RC_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PEND_ON  = 2'd1,
        ON       = 2'd2,
        PEND_OFF = 2'd3
    } qual_state_t;

    // True for the six legal relation encodings.
    function automatic logic sel_legal(input logic [2:0] s);
        return (s <= SEL_EQ);
    endfunction

    // Zero-extending the flag vector to 8 bits makes the illegal encodings
    // 6 and 7 land on constant-zero bits, so the chosen relation reads false.
    function automatic logic select_flag(input logic [5:0] f, input logic [2:0] s);
        logic [7:0] f_ext;
        f_ext = {2'b00, f};
        return f_ext[s];
    endfunction

endpackage : cmp_pkg

// File: rtl/cmp_persist_ctr.sv
// ---------------------------------------------------------------------------
// cmp_persist_ctr
//   Run counter for the event qualifier. Counts consecutive qualifying samples
//   and flags the sample that completes a run of PERSIST.
//   Ports:
//     clk   in  1  clock
//     rst   in  1  synchronous active-high reset
//     inc   in  1  the current cycle carries a sample that extends the run
//     clr   in  1  abandon the current run (wins over inc)
//     done  out 1  combinational: the incoming inc sample is the PERSIST-th
//   The counter wraps to 0 on the completing sample, so it is ready for the
//   opposite-direction run without an extra clear.
// ---------------------------------------------------------------------------
module cmp_persist_ctr
    import cmp_pkg::*;
#(
    parameter int unsigned PERSIST = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic done
);

    localparam logic [RC_W-1:0] LAST = RC_W'(PERSIST - 1);

    logic [RC_W-1:0] r_rc;

    // With PERSIST==1, LAST is 0 and every inc sample completes a run.
    assign done = inc & (r_rc == LAST);

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rc <= '0;
        end else if (clr) begin
            r_rc <= '0;
        end else if (inc) begin
            if (done) begin
                r_rc <= '0;
            end else begin
                r_rc <= r_rc + RC_W'(1);
            end
        end
    end

endmodule : cmp_persist_ctr

// File: rtl/cmp_event_qualifier.sv
// ---------------------------------------------------------------------------
// cmp_event_qualifier
//   Downstream stage of the 4-bit magnitude comparator. Selects one relation
//   from the flag vector, debounces it with symmetric hysteresis of PERSIST
//   consecutive valid samples, and counts qualified trigger rises.
//   Ports:
//     clk         in  1      clock, all state on rising edge
//     rst         in  1      synchronous active-high reset
//     flags       in  6      [5]eq [4]ne [3]gt [2]lt [1]ge [0]le
//     flags_vld   in  1      flags carry a new sample this cycle
//     sel         in  3      relation index 0..5; 6/7 illegal
//     clr_cnt     in  1      clear event_cnt (beats a coincident increment)
//     trig        out 1      qualified trigger level
//     trig_pulse  out 1      high in the first cycle trig reads 1
//     event_cnt   out CNT_W  saturating count of trig rises
//     sel_err     out 1      high one cycle after sel becomes illegal
//   All outputs come straight from flops.
// ---------------------------------------------------------------------------
module cmp_event_qualifier
    import cmp_pkg::*;
#(
    parameter int unsigned PERSIST = 3,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       flags,
    input  logic             flags_vld,
    input  logic [2:0]       sel,
    input  logic             clr_cnt,
    output logic             trig,
    output logic             trig_pulse,
    output logic [CNT_W-1:0] event_cnt,
    output logic             sel_err
);

    qual_state_t      r_state;
    logic [2:0]       r_sel;
    logic             r_trig;
    logic             r_trig_pulse;
    logic [CNT_W-1:0] r_event_cnt;
    logic             r_sel_err;

    logic w_cond;
    logic w_sel_chg;
    logic w_smp;
    logic w_run_inc;
    logic w_run_clr;
    logic w_done;
    logic w_rise;
    logic w_trig_side;

    // Illegal sel forces cond low, which drains the FSM toward IDLE.
    assign w_cond    = select_flag(flags, sel);
    // A sel change restarts qualification; that cycle's sample is discarded.
    assign w_sel_chg = (sel != r_sel);
    assign w_smp     = flags_vld & ~w_sel_chg;

    // ON and PEND_OFF are the states where trig reads high; there the run
    // being counted is a run of false samples.
    assign w_trig_side = (r_state == ON) || (r_state == PEND_OFF);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_run_inc = 1'b0;
        if (w_smp) begin
            w_run_inc = w_trig_side ? ~w_cond : w_cond;
        end
    end

    // A sample against the current run direction abandons a pending run.
    assign w_run_clr = w_sel_chg
                     | (w_smp & (r_state == PEND_ON)  & ~w_cond)
                     | (w_smp & (r_state == PEND_OFF) &  w_cond);

    cmp_persist_ctr #(
        .PERSIST (PERSIST)
    ) u_persist_ctr (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_run_inc),
        .clr  (w_run_clr),
        .done (w_done)
    );

    // The completing true sample out of IDLE/PEND_ON is the trig rise.
    assign w_rise = w_run_inc & w_done & ~w_trig_side;

    // Debounce FSM; trig and trig_pulse are registered in step with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_trig       <= 1'b0;
            r_trig_pulse <= 1'b0;
        end else begin
            r_trig_pulse <= w_rise;
            if (w_sel_chg) begin
                r_state <= IDLE;
                r_trig  <= 1'b0;
            end else if (w_smp) begin
                unique case (r_state)
                    IDLE: begin
                        if (w_cond) begin
                            if (w_done) begin
                                r_state <= ON;
                                r_trig  <= 1'b1;
                            end else begin
                                r_state <= PEND_ON;
                            end
                        end
                    end
                    PEND_ON: begin
                        if (!w_cond) begin
                            r_state <= IDLE;
                        end else if (w_done) begin
                            r_state <= ON;
                            r_trig  <= 1'b1;
                        end
                    end
                    ON: begin
                        if (!w_cond) begin
                            if (w_done) begin
                                r_state <= IDLE;
                                r_trig  <= 1'b0;
                            end else begin
                                r_state <= PEND_OFF;
                            end
                        end
                    end
                    PEND_OFF: begin
                        if (w_cond) begin
                            r_state <= ON;
                        end else if (w_done) begin
                            r_state <= IDLE;
                            r_trig  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_trig  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating event counter; a clear drops a coincident rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_event_cnt <= '0;
        end else if (clr_cnt) begin
            r_event_cnt <= '0;
        end else if (w_rise && (r_event_cnt != {CNT_W{1'b1}})) begin
            r_event_cnt <= r_event_cnt + CNT_W'(1);
        end
    end

    // Previous-cycle sel for change detection, and the registered error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel     <= SEL_LE;
            r_sel_err <= 1'b0;
        end else begin
            r_sel     <= sel;
            r_sel_err <= ~sel_legal(sel);
        end
    end

    assign trig       = r_trig;
    assign trig_pulse = r_trig_pulse;
    assign event_cnt  = r_event_cnt;
    assign sel_err    = r_sel_err;

endmodule : cmp_event_qualifier

// File: tb/tb_cmp_event_qualifier.sv
// ---------------------------------------------------------------------------
// tb_cmp_event_qualifier
//   Three instances share one stimulus stream:
//     id 0 : PERSIST=3, CNT_W=8   (main behaviour)
//     id 1 : PERSIST=3, CNT_W=2   (saturation and clear)
//     id 2 : PERSIST=1, CNT_W=8   (single-sample qualification)
//   Each stimulus cycle pushes the hand-computed outputs expected after its
//   clock edge, tagged with the instance under test; a monitor pops one entry
//   per falling edge and compares.
// ---------------------------------------------------------------------------
module tb_cmp_event_qualifier;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] flags = '0;
    logic       flags_vld = 1'b0;
    logic [2:0] sel = 3'd0;
    logic       clr_cnt = 1'b0;

    logic       trig_a, pulse_a, err_a;
    logic [7:0] cnt_a;
    logic       trig_b, pulse_b, err_b;
    logic [1:0] cnt_b;
    logic       trig_c, pulse_c, err_c;
    logic [7:0] cnt_c;

    // gt true (A=14,B=13), gt false (A<B), eq true, all flags set
    localparam logic [5:0] FT = 6'b011010;
    localparam logic [5:0] FF = 6'b010101;
    localparam logic [5:0] FE = 6'b100011;
    localparam logic [5:0] FA = 6'b111111;

    always #5 clk = ~clk;

    cmp_event_qualifier #(.PERSIST(3), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .flags(flags), .flags_vld(flags_vld), .sel(sel),
        .clr_cnt(clr_cnt), .trig(trig_a), .trig_pulse(pulse_a),
        .event_cnt(cnt_a), .sel_err(err_a)
    );

    cmp_event_qualifier #(.PERSIST(3), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .flags(flags), .flags_vld(flags_vld), .sel(sel),
        .clr_cnt(clr_cnt), .trig(trig_b), .trig_pulse(pulse_b),
        .event_cnt(cnt_b), .sel_err(err_b)
    );

    cmp_event_qualifier #(.PERSIST(1), .CNT_W(8)) u_dut_c (
        .clk(clk), .rst(rst), .flags(flags), .flags_vld(flags_vld), .sel(sel),
        .clr_cnt(clr_cnt), .trig(trig_c), .trig_pulse(pulse_c),
        .event_cnt(cnt_c), .sel_err(err_c)
    );

    typedef struct {
        int         id;
        logic       trig;
        logic       pulse;
        logic [7:0] cnt;
        logic       err;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   cur_id = 0;
    int   n_cmp  = 0;
    int   n_mis  = 0;

    // Monitor: one expected entry per falling edge, compared against the
    // instance it names.
    initial begin
        exp_t       e;
        logic       a_trig, a_pulse, a_err;
        logic [7:0] a_cnt;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                case (e.id)
                    0:       begin a_trig = trig_a; a_pulse = pulse_a; a_cnt = cnt_a;          a_err = err_a; end
                    1:       begin a_trig = trig_b; a_pulse = pulse_b; a_cnt = {6'b0, cnt_b}; a_err = err_b; end
                    default: begin a_trig = trig_c; a_pulse = pulse_c; a_cnt = cnt_c;          a_err = err_c; end
                endcase
                n_cmp++;
                if (a_trig !== e.trig || a_pulse !== e.pulse || a_cnt !== e.cnt || a_err !== e.err) begin
                    n_mis++;
                    $display("FAIL %s (dut %0d): got trig=%0b pulse=%0b cnt=%0d err=%0b, want trig=%0b pulse=%0b cnt=%0d err=%0b",
                             e.tag, e.id, a_trig, a_pulse, a_cnt, a_err, e.trig, e.pulse, e.cnt, e.err);
                end
            end
        end
    end

    task automatic push_exp(input logic et, input logic ep, input logic [7:0] ec,
                            input logic ee, input string tag);
        exp_t e;
        e.id = cur_id; e.trig = et; e.pulse = ep; e.cnt = ec; e.err = ee; e.tag = tag;
        sb_q.push_back(e);
    endtask

    // One functional cycle: drive on the falling edge, expect after the rise.
    task automatic step(input logic v, input logic [5:0] f, input logic [2:0] s,
                        input logic c, input logic et, input logic ep,
                        input logic [7:0] ec, input logic ee, input string tag);
        @(negedge clk);
        rst = 1'b0; flags_vld = v; flags = f; sel = s; clr_cnt = c;
        @(posedge clk);
        #1;
        push_exp(et, ep, ec, ee, tag);
    endtask

    // Reset held with random inputs; every output must read 0.
    task automatic reset_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            flags = 6'($urandom); flags_vld = 1'($urandom);
            sel = 3'($urandom);   clr_cnt = 1'($urandom);
            @(posedge clk);
            #1;
            push_exp(1'b0, 1'b0, 8'd0, 1'b0, tag);
        end
    endtask

    initial begin
        int sat_prev [4] = '{0, 1, 2, 3};
        int sat_exp  [4] = '{1, 2, 3, 3};

        // ---------------- instance 0: PERSIST=3, CNT_W=8 ----------------
        cur_id = 0;
        reset_cycles(2, "reset");
        step(0, FF, 3'd3, 0, 0, 0, 8'd0, 0, "idle_after_reset");

        step(1, FT, 3'd3, 0, 0, 0, 8'd0, 0, "qual_s1");
        step(1, FT, 3'd3, 0, 0, 0, 8'd0, 0, "qual_s2");
        step(1, FT, 3'd3, 0, 1, 1, 8'd1, 0, "qual_rise");
        step(0, FT, 3'd3, 0, 1, 0, 8'd1, 0, "qual_hold");

        step(1, FF, 3'd3, 0, 1, 0, 8'd1, 0, "hyst_f1");
        step(1, FF, 3'd3, 0, 1, 0, 8'd1, 0, "hyst_f2");
        step(1, FT, 3'd3, 0, 1, 0, 8'd1, 0, "hyst_back_on");
        step(1, FF, 3'd3, 0, 1, 0, 8'd1, 0, "hyst_f1b");
        step(1, FF, 3'd3, 0, 1, 0, 8'd1, 0, "hyst_f2b");
        step(1, FF, 3'd3, 0, 0, 0, 8'd1, 0, "hyst_release");
        step(1, FF, 3'd3, 0, 0, 0, 8'd1, 0, "idle_false");

        step(1, FT, 3'd3, 0, 0, 0, 8'd1, 0, "on2_s1");
        step(1, FT, 3'd3, 0, 0, 0, 8'd1, 0, "on2_s2");
        step(1, FT, 3'd3, 0, 1, 1, 8'd2, 0, "on2_rise");
        reset_cycles(2, "reset_in_on");
        step(0, FF, 3'd3, 0, 0, 0, 8'd0, 0, "idle_after_reset2");

        step(1, FT, 3'd3, 0, 0, 0, 8'd0, 0, "gap_s1");
        step(0, FF, 3'd3, 0, 0, 0, 8'd0, 0, "gap_g1");
        step(1, FT, 3'd3, 0, 0, 0, 8'd0, 0, "gap_s2");
        step(0, FF, 3'd3, 0, 0, 0, 8'd0, 0, "gap_g2");
        step(0, FF, 3'd3, 0, 0, 0, 8'd0, 0, "gap_g3");
        step(1, FT, 3'd3, 0, 1, 1, 8'd1, 0, "gap_rise");
        step(1, FF, 3'd3, 0, 1, 0, 8'd1, 0, "gap_f1");
        step(1, FF, 3'd3, 0, 1, 0, 8'd1, 0, "gap_f2");
        step(1, FF, 3'd3, 0, 0, 0, 8'd1, 0, "gap_release");

        step(1, FT, 3'd3, 0, 0, 0, 8'd1, 0, "glitch_t1");
        step(1, FT, 3'd3, 0, 0, 0, 8'd1, 0, "glitch_t2");
        step(1, FF, 3'd3, 0, 0, 0, 8'd1, 0, "glitch_f");
        step(1, FT, 3'd3, 0, 0, 0, 8'd1, 0, "glitch_t3");
        step(1, FT, 3'd3, 0, 0, 0, 8'd1, 0, "glitch_t4");
        step(1, FT, 3'd3, 0, 1, 1, 8'd2, 0, "glitch_rise");

        step(0, FT, 3'd5, 0, 0, 0, 8'd2, 0, "sel_chg_drop");
        step(1, FE, 3'd5, 0, 0, 0, 8'd2, 0, "sel5_s1");
        step(1, FE, 3'd5, 0, 0, 0, 8'd2, 0, "sel5_s2");
        step(1, FE, 3'd5, 0, 1, 1, 8'd3, 0, "sel5_rise");

        step(0, FA, 3'd6, 0, 0, 0, 8'd3, 1, "sel6_err");
        for (int i = 0; i < 4; i++)
            step(1, FA, 3'd6, 0, 0, 0, 8'd3, 1, "sel6_no_trig");
        step(0, FA, 3'd3, 0, 0, 0, 8'd3, 0, "sel_legal_again");
        step(0, FF, 3'd3, 1, 0, 0, 8'd0, 0, "clr_cnt");

        // ---------------- instance 1: PERSIST=3, CNT_W=2 ----------------
        cur_id = 1;
        reset_cycles(2, "b_reset");
        step(0, FF, 3'd3, 0, 0, 0, 8'd0, 0, "b_idle");
        for (int k = 0; k < 4; k++) begin
            step(1, FT, 3'd3, 0, 0, 0, 8'(sat_prev[k]), 0, "b_s1");
            step(1, FT, 3'd3, 0, 0, 0, 8'(sat_prev[k]), 0, "b_s2");
            step(1, FT, 3'd3, 0, 1, 1, 8'(sat_exp[k]),  0, "b_rise");
            step(1, FF, 3'd3, 0, 1, 0, 8'(sat_exp[k]),  0, "b_f1");
            step(1, FF, 3'd3, 0, 1, 0, 8'(sat_exp[k]),  0, "b_f2");
            step(1, FF, 3'd3, 0, 0, 0, 8'(sat_exp[k]),  0, "b_release");
        end
        step(1, FT, 3'd3, 0, 0, 0, 8'd3, 0, "b5_s1");
        step(1, FT, 3'd3, 0, 0, 0, 8'd3, 0, "b5_s2");
        step(1, FT, 3'd3, 1, 1, 1, 8'd0, 0, "b5_rise_with_clr");
        step(0, FT, 3'd3, 0, 1, 0, 8'd0, 0, "b5_hold");

        // ---------------- instance 2: PERSIST=1, CNT_W=8 ----------------
        cur_id = 2;
        reset_cycles(2, "c_reset");
        step(0, FF, 3'd3, 0, 0, 0, 8'd0, 0, "c_idle");
        step(1, FT, 3'd3, 0, 1, 1, 8'd1, 0, "c_rise1");
        step(1, FT, 3'd3, 0, 1, 0, 8'd1, 0, "c_stay_on");
        step(1, FF, 3'd3, 0, 0, 0, 8'd1, 0, "c_fall1");
        step(0, FT, 3'd3, 0, 0, 0, 8'd1, 0, "c_gap_off");
        step(1, FT, 3'd3, 0, 1, 1, 8'd2, 0, "c_rise2");
        step(0, FF, 3'd3, 0, 1, 0, 8'd2, 0, "c_gap_on");
        step(1, FF, 3'd3, 0, 0, 0, 8'd2, 0, "c_fall2");
        step(1, FT, 3'd3, 0, 1, 1, 8'd3, 0, "c_rise3");

        // Let the monitor drain; anything left means the monitor stalled.
        repeat (3) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        n_mis++;
        $display("FAIL watchdog: got no completion by 200000 time units, want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_cmp_event_qualifier
